// File: rtl/gpio_lb_pkg.sv
// Shared types and helpers for the GPIO loopback fixture (gpio_loopback_pipe).
package gpio_lb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_ONCHG = 2'd3
  } err_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ONCHG = 2'd2
  } fsm_state_e;

  // Mask that flips only the parity bit (MSB) of a word of the given width.
  function automatic logic [31:0] PARITY_MASK(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/gpio_lb_delay.sv
// Leading (LATENCY-1) stages of the loopback pipeline: plain WIDTH x DEPTH shift register.
module gpio_lb_delay #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  // NOTE: every stage is cleared so a reset leaves no stale word in flight;
  // this array is small registers, not a RAM, so resetting it is cheap and intended.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/gpio_loopback_pipe.sv
// GPIO loopback with configurable latency and XOR fault injection (OFF/CONT/BURST/ONCHG).
// Optional saturating statistics counters are enabled by defining GPIO_LB_STATS_EN.
module gpio_loopback_pipe
  import gpio_lb_pkg::*;
#(
  parameter int WIDTH   = 17,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  GPIOOUT,
  output logic [WIDTH-1:0]  GPIOIN,
  input  logic [1:0]        err_mode,
  input  logic [WIDTH-1:0]  err_mask,
  input  logic [CNT_W-1:0]  err_len,
  input  logic              err_start,
  output logic              err_busy
`ifdef GPIO_LB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_changes,
  output logic [STAT_W-1:0] stat_injected
`endif
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] final_clean;
  logic             chg;
  logic             inj;
  err_mode_e        mode;
  fsm_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  generate
    if (LATENCY > 1) begin : g_delay
      gpio_lb_delay #(
        .WIDTH (WIDTH),
        .DEPTH (LATENCY - 1)
      ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (GPIOOUT),
        .q       (nxt)
      );
    end else begin : g_direct
      assign nxt = GPIOOUT;
    end
  endgenerate

  assign mode     = err_mode_e'(err_mode);
  // Change is judged on clean data so an injected flip never looks like a new word.
  assign chg      = (nxt != final_clean);
  assign inj      = (mode == MODE_CONT) || (state == ST_BURST) || ((state == ST_ONCHG) && chg);
  assign err_busy = (state != ST_IDLE);

  // NOTE: defaults first so every path assigns every output; no latches inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (err_start) begin
          if (mode == MODE_BURST && err_len != '0) begin
            state_nxt = ST_BURST;
            cnt_nxt   = err_len;
          end else if (mode == MODE_ONCHG) begin
            state_nxt = ST_ONCHG;
          end
        end
      end
      ST_BURST: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ONCHG: begin
        if (chg) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      final_clean <= '0;
      GPIOIN      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      final_clean <= nxt;
      GPIOIN      <= nxt ^ (inj ? err_mask : '0);
    end
  end

`ifdef GPIO_LB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_changes  <= '0;
      stat_injected <= '0;
    end else begin
      if (chg && stat_changes != '1)  stat_changes  <= stat_changes + STAT_W'(1);
      if (inj && stat_injected != '1) stat_injected <= stat_injected + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gpio_loopback_pipe.sv
// Self-checking bench for gpio_loopback_pipe against a queue-based reference model.
module tb_gpio_loopback_pipe;
  import gpio_lb_pkg::*;

  localparam int W  = 17;
  localparam int L  = 3;
  localparam int CW = 8;
  localparam int SW = 8;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  gpioout;
  logic [W-1:0]  gpioin;
  logic [1:0]    err_mode;
  logic [W-1:0]  err_mask;
  logic [CW-1:0] err_len;
  logic          err_start;
  logic          err_busy;
`ifdef GPIO_LB_STATS_EN
  logic [SW-1:0] stat_changes;
  logic [SW-1:0] stat_injected;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] m_pipe [$];
  logic [W-1:0] m_out;
  int           m_remaining;
  bit           m_armed;
  int           m_changes;
  int           m_injected;
  int           sat_max = (1 << SW) - 1;

  gpio_loopback_pipe #(
    .WIDTH   (W),
    .LATENCY (L),
    .CNT_W   (CW),
    .STAT_W  (SW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .GPIOOUT   (gpioout),
    .GPIOIN    (gpioin),
    .err_mode  (err_mode),
    .err_mask  (err_mask),
    .err_len   (err_len),
    .err_start (err_start),
    .err_busy  (err_busy)
`ifdef GPIO_LB_STATS_EN
    ,
    .stat_changes  (stat_changes),
    .stat_injected (stat_injected)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_busy();
    return (m_remaining > 0) || m_armed;
  endfunction

  // One clock: advance the model with the inputs the DUT samples, then settle 1ns past the edge.
  task automatic step();
    logic [W-1:0] nxt;
    bit           chg, inj;
    @(posedge clk);
    if (!reset_n) begin
      m_pipe.delete();
      for (int i = 0; i < L; i++) m_pipe.push_back('0);
      m_out       = '0;
      m_remaining = 0;
      m_armed     = 1'b0;
      m_changes   = 0;
      m_injected  = 0;
    end else begin
      nxt = (L == 1) ? gpioout : m_pipe[L-2];
      chg = (nxt != m_pipe[L-1]);
      inj = (err_mode == MODE_CONT) || (m_remaining > 0) || (m_armed && chg);
      m_out = nxt ^ (inj ? err_mask : '0);
      if (chg && m_changes < sat_max)  m_changes++;
      if (inj && m_injected < sat_max) m_injected++;
      m_pipe.push_front(gpioout);
      void'(m_pipe.pop_back());
      if (m_remaining > 0) m_remaining--;
      else if (m_armed) begin
        if (chg) m_armed = 1'b0;
      end else if (err_start) begin
        if (err_mode == MODE_BURST && err_len != '0) m_remaining = int'(err_len);
        else if (err_mode == MODE_ONCHG) m_armed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; gpioout = 17'h1FFFF; err_mode = MODE_OFF; err_mask = '0;
    err_len = '0; err_start = 1'b0;
    repeat (3) step();
    n_tests++;
    if (gpioin !== '0) begin n_fail++; $display("FAIL reset_gpioin: got %h want 00000", gpioin); end
    n_tests++;
    if (err_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", err_busy); end
`ifdef GPIO_LB_STATS_EN
    n_tests++;
    if (stat_changes !== '0 || stat_injected !== '0) begin
      n_fail++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_changes, stat_injected);
    end
`endif
    reset_n = 1'b1;
    for (int i = 1; i <= L; i++) begin
      step();
      n_tests++;
      if (gpioin !== ((i == L) ? 17'h1FFFF : 17'h00000)) begin
        n_fail++; $display("FAIL reset_release_c%0d: got %h want %h", i, gpioin, m_out);
      end
    end
  endtask

  task automatic test_clean_loop();
    logic [W-1:0] vals [3] = '{17'h00001, 17'h0AAAA, 17'h15555};
    err_mode = MODE_OFF;
    for (int i = 0; i < 3 + L; i++) begin
      if (i < 3) gpioout = vals[i];
      step();
      n_tests++;
      if (gpioin !== m_out || (i >= L - 1 && i < L + 2 && gpioin !== vals[i-L+1])) begin
        n_fail++; $display("FAIL clean_loop_c%0d: got %h want %h", i, gpioin, m_out);
      end
    end
  endtask

  task automatic test_cont();
    err_mode = MODE_CONT; err_mask = 17'h10000; gpioout = 17'h0AAAA;
    repeat (L) step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (gpioin !== 17'h1AAAA) begin n_fail++; $display("FAIL cont_on_c%0d: got %h want 1aaaa", i, gpioin); end
    end
    err_mode = MODE_OFF;
    for (int i = 0; i < L + 1; i++) begin
      step();
      n_tests++;
      if (gpioin !== m_out) begin n_fail++; $display("FAIL cont_off_c%0d: got %h want %h", i, gpioin, m_out); end
    end
    n_tests++;
    if (gpioin !== 17'h0AAAA) begin n_fail++; $display("FAIL cont_off_final: got %h want 0aaaa", gpioin); end
  endtask

  task automatic test_burst();
    int corrupted = 0;
    int busy_cnt  = 0;
    err_mode = MODE_OFF; gpioout = 17'h00010;
    repeat (L + 1) step();
    err_mode = MODE_BURST; err_len = 8'd4; err_mask = 17'h00001; err_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      err_start = (i == 1);
      if (gpioin === 17'h00011) corrupted++;
      if (err_busy === 1'b1) busy_cnt++;
      n_tests++;
      if (gpioin !== m_out || err_busy !== exp_busy()) begin
        n_fail++; $display("FAIL burst_c%0d: got %h/%b want %h/%b", i, gpioin, err_busy, m_out, exp_busy());
      end
    end
    err_start = 1'b0;
    n_tests++;
    if (corrupted != 4) begin n_fail++; $display("FAIL burst_count: got %0d want 4", corrupted); end
    n_tests++;
    if (busy_cnt != 4) begin n_fail++; $display("FAIL burst_busy_cycles: got %0d want 4", busy_cnt); end
  endtask

  task automatic test_burst_zero_and_onchg();
    int corrupted = 0;
    err_mode = MODE_BURST; err_len = '0; err_mask = 17'h1FFFF; err_start = 1'b1;
    step(); err_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (err_busy !== 1'b0 || gpioin !== 17'h00010) begin
        n_fail++; $display("FAIL burst_zero_c%0d: got %h/%b want 00010/0", i, gpioin, err_busy);
      end
    end
    err_mode = MODE_OFF; gpioout = 17'h00000;
    repeat (L + 1) step();
    err_mode = MODE_ONCHG; err_mask = 17'h10000; err_start = 1'b1;
    step(); err_start = 1'b0;
    repeat (5) step();
    n_tests++;
    if (err_busy !== 1'b1) begin n_fail++; $display("FAIL onchg_armed: got %b want 1", err_busy); end
    gpioout = 17'h0FFFF;
    for (int i = 0; i < L + 3; i++) begin
      step();
      if (gpioin === 17'h1FFFF) corrupted++;
      n_tests++;
      if (gpioin !== m_out || err_busy !== exp_busy()) begin
        n_fail++; $display("FAIL onchg_c%0d: got %h/%b want %h/%b", i, gpioin, err_busy, m_out, exp_busy());
      end
    end
    n_tests++;
    if (corrupted != 1) begin n_fail++; $display("FAIL onchg_count: got %0d want 1", corrupted); end
  endtask

  task automatic test_reset_mid_burst();
    err_mode = MODE_OFF; gpioout = 17'h00100;
    repeat (L + 1) step();
    err_mode = MODE_BURST; err_len = 8'd5; err_mask = 17'h00003; err_start = 1'b1;
    step(); err_start = 1'b0;
    repeat (2) step();
    reset_n = 1'b0;
    step();
    n_tests++;
    if (err_busy !== 1'b0 || gpioin !== '0) begin
      n_fail++; $display("FAIL reset_mid_burst: got %h/%b want 00000/0", gpioin, err_busy);
    end
    reset_n = 1'b1;
    for (int i = 0; i < L + 4; i++) begin
      step();
      n_tests++;
      if (gpioin !== m_out || err_busy !== 1'b0 || gpioin === 17'h00103) begin
        n_fail++; $display("FAIL post_reset_c%0d: got %h/%b want %h/0", i, gpioin, err_busy, m_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) gpioout = W'($urandom());
      if ($urandom_range(0, 9) == 0) err_mode = 2'($urandom_range(0, 3));
      err_mask  = W'($urandom());
      err_len   = CW'($urandom_range(0, 6));
      err_start = ($urandom_range(0, 7) == 0);
      reset_n   = ($urandom_range(0, 79) != 0);
      step();
      n_tests++;
      if (gpioin !== m_out || err_busy !== exp_busy()) begin
        n_fail++; $display("FAIL random_c%0d: got %h/%b want %h/%b", i, gpioin, err_busy, m_out, exp_busy());
      end
`ifdef GPIO_LB_STATS_EN
      n_tests++;
      if (int'(stat_changes) != m_changes || int'(stat_injected) != m_injected) begin
        n_fail++; $display("FAIL random_stats_c%0d: got %0d/%0d want %0d/%0d",
                           i, stat_changes, stat_injected, m_changes, m_injected);
      end
`endif
    end
    reset_n = 1'b1; err_start = 1'b0;
  endtask

`ifdef GPIO_LB_STATS_EN
  task automatic test_stats_saturate();
    logic [31:0] pm;
    pm = PARITY_MASK(W);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    err_mode = MODE_CONT; err_mask = pm[W-1:0]; gpioout = 17'h00055;
    repeat (300) step();
    n_tests++;
    if (stat_injected !== 8'hFF) begin n_fail++; $display("FAIL stat_inj_sat: got %h want ff", stat_injected); end
    n_tests++;
    if (int'(stat_changes) != m_changes) begin
      n_fail++; $display("FAIL stat_chg: got %0d want %0d", stat_changes, m_changes);
    end
    err_mode = MODE_OFF;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_loop();
    test_cont();
    test_burst();
    test_burst_zero_and_onchg();
    test_reset_mid_burst();
    test_random();
`ifdef GPIO_LB_STATS_EN
    test_stats_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
